// File: rtl/axil_user_master_if.sv
// AXI4-Lite master-side bus bundle used between axil_user_master and the
// interconnect/slave. Signal names follow the AXI channel naming.
interface axil_user_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    // AW channel
    logic [ADDR_W-1:0]   M_AWADDR;
    logic                M_AWVALID;
    logic                M_AWREADY;
    // W channel
    logic [DATA_W-1:0]   M_WDATA;
    logic [DATA_W/8-1:0] M_WSTRB;
    logic                M_WVALID;
    logic                M_WREADY;
    // B channel
    logic [1:0]          M_BRESP;
    logic                M_BVALID;
    logic                M_BREADY;
    // AR channel
    logic [ADDR_W-1:0]   M_ARADDR;
    logic                M_ARVALID;
    logic                M_ARREADY;
    // R channel
    logic [DATA_W-1:0]   M_RDATA;
    logic [1:0]          M_RRESP;
    logic                M_RVALID;
    logic                M_RREADY;

    modport master (
        output M_AWADDR, M_AWVALID, input M_AWREADY,
        output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
        input M_BRESP, M_BVALID, output M_BREADY,
        output M_ARADDR, M_ARVALID, input M_ARREADY,
        input M_RDATA, M_RRESP, M_RVALID, output M_RREADY
    );

    modport slave (
        input M_AWADDR, M_AWVALID, output M_AWREADY,
        input M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
        output M_BRESP, M_BVALID, input M_BREADY,
        input M_ARADDR, M_ARVALID, output M_ARREADY,
        output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
    );
endinterface

// File: rtl/axil_user_master.sv
// User request to AXI4-Lite master bridge. Writes map to one AXI-Lite write;
// reads expand into U_BLEN+1 single-beat reads at incrementing addresses.
// Every output is a register; next values are computed combinationally.
module axil_user_master #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_INC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                U_WVALID,
    input  logic [ADDR_W-1:0]   U_AWADDR,
    input  logic [DATA_W-1:0]   U_WDATA,
    input  logic [DATA_W/8-1:0] U_STRB,
    input  logic                U_RVALID,
    input  logic [ADDR_W-1:0]   U_ARADDR,
    input  logic [3:0]          U_BLEN,
    output logic [DATA_W-1:0]   U_RDATA,
    output logic                U_BUSY,
    output logic                U_WDONE,
    output logic                U_RDONE,
    output logic                U_ERR,
    axil_user_master_if.master  m_axil
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_AR,
        S_RD_R
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [3:0]          blen_q, blen_d;
    logic [3:0]          beat_q, beat_d;
    logic                acc_q, acc_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                wdone_q, wdone_d;
    logic                rdone_q, rdone_d;
    logic                err_q, err_d;

    logic                aw_done;
    logic                w_done;
    logic [3:0]          beat_inc;
    logic [ADDR_W-1:0]   beat_offset;

    // Next-state and next-output computation for all registered signals
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        base_d      = base_q;
        blen_d      = blen_q;
        beat_d      = beat_q;
        acc_d       = acc_q;
        rdata_d     = rdata_q;
        wdone_d     = 1'b0;
        rdone_d     = 1'b0;
        err_d       = 1'b0;
        aw_done     = !awvalid_q || m_axil.M_AWREADY;
        w_done      = !wvalid_q || m_axil.M_WREADY;
        beat_inc    = beat_q + 4'd1;
        beat_offset = ADDR_W'(beat_inc) * ADDR_W'(ADDR_INC);

        case (state_q)
            S_IDLE: begin
                if (U_WVALID) begin
                    awaddr_d  = U_AWADDR;
                    wdata_d   = U_WDATA;
                    wstrb_d   = U_STRB;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = S_WR;
                end else if (U_RVALID) begin
                    base_d    = U_ARADDR;
                    blen_d    = U_BLEN;
                    beat_d    = '0;
                    acc_d     = 1'b0;
                    araddr_d  = U_ARADDR;
                    arvalid_d = 1'b1;
                    state_d   = S_RD_AR;
                end
            end
            S_WR: begin
                // AW and W complete independently; leave once both have
                if (awvalid_q && m_axil.M_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && m_axil.M_WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_B;
                end
            end
            S_WR_B: begin
                if (m_axil.M_BVALID) begin
                    bready_d = 1'b0;
                    wdone_d  = 1'b1;
                    err_d    = m_axil.M_BRESP[1];
                    state_d  = S_IDLE;
                end
            end
            S_RD_AR: begin
                if (m_axil.M_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end
            end
            S_RD_R: begin
                if (m_axil.M_RVALID) begin
                    rdata_d  = m_axil.M_RDATA;
                    acc_d    = acc_q | m_axil.M_RRESP[1];
                    rready_d = 1'b0;
                    if (beat_q == blen_q) begin
                        rdone_d = 1'b1;
                        err_d   = acc_q | m_axil.M_RRESP[1];
                        state_d = S_IDLE;
                    end else begin
                        beat_d    = beat_inc;
                        araddr_d  = base_q + beat_offset;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_AR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops every VALID/READY at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            base_q    <= '0;
            blen_q    <= '0;
            beat_q    <= '0;
            acc_q     <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            wdone_q   <= 1'b0;
            rdone_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            base_q    <= base_d;
            blen_q    <= blen_d;
            beat_q    <= beat_d;
            acc_q     <= acc_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            wdone_q   <= wdone_d;
            rdone_q   <= rdone_d;
            err_q     <= err_d;
        end
    end

    assign m_axil.M_AWADDR  = awaddr_q;
    assign m_axil.M_AWVALID = awvalid_q;
    assign m_axil.M_WDATA   = wdata_q;
    assign m_axil.M_WSTRB   = wstrb_q;
    assign m_axil.M_WVALID  = wvalid_q;
    assign m_axil.M_BREADY  = bready_q;
    assign m_axil.M_ARADDR  = araddr_q;
    assign m_axil.M_ARVALID = arvalid_q;
    assign m_axil.M_RREADY  = rready_q;

    assign U_RDATA = rdata_q;
    assign U_BUSY  = busy_q;
    assign U_WDONE = wdone_q;
    assign U_RDONE = rdone_q;
    assign U_ERR   = err_q;

endmodule

// File: tb/tb_axil_user_master.sv
// Directed bench for axil_user_master with a small registered AXI-Lite slave
// that returns the read address as data.
module tb_axil_user_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        u_wvalid = 1'b0;
    logic [31:0] u_awaddr = '0;
    logic [31:0] u_wdata = '0;
    logic [3:0]  u_strb = '0;
    logic        u_rvalid = 1'b0;
    logic [31:0] u_araddr = '0;
    logic [3:0]  u_blen = '0;
    logic [31:0] u_rdata;
    logic        u_busy, u_wdone, u_rdone, u_err;

    logic        aw_ready = 1'b1;
    logic        w_ready = 1'b1;
    logic        ar_ready = 1'b1;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] err_addr = 32'h0000_0BAD;

    int tests = 0;
    int failed = 0;
    int wdone_cnt = 0;
    int rdone_cnt = 0;
    logic [31:0] ar_log [0:63];
    int ar_cnt = 0;
    logic aw_seen = 1'b0;
    logic w_seen = 1'b0;

    axil_user_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_user_master #(.ADDR_W(32), .DATA_W(32), .ADDR_INC(4)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .U_WVALID (u_wvalid),
        .U_AWADDR (u_awaddr),
        .U_WDATA  (u_wdata),
        .U_STRB   (u_strb),
        .U_RVALID (u_rvalid),
        .U_ARADDR (u_araddr),
        .U_BLEN   (u_blen),
        .U_RDATA  (u_rdata),
        .U_BUSY   (u_busy),
        .U_WDONE  (u_wdone),
        .U_RDONE  (u_rdone),
        .U_ERR    (u_err),
        .m_axil   (bus)
    );

    always #5 clk = ~clk;

    assign bus.M_AWREADY = aw_ready;
    assign bus.M_WREADY  = w_ready;
    assign bus.M_ARREADY = ar_ready;

    // Registered slave: B after both AW and W, R one cycle after AR
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.M_BVALID <= 1'b0;
            bus.M_BRESP  <= 2'b00;
            bus.M_RVALID <= 1'b0;
            bus.M_RDATA  <= '0;
            bus.M_RRESP  <= 2'b00;
            aw_seen      <= 1'b0;
            w_seen       <= 1'b0;
        end else begin
            if (bus.M_BVALID && bus.M_BREADY) bus.M_BVALID <= 1'b0;
            if ((aw_seen || (bus.M_AWVALID && bus.M_AWREADY)) &&
                (w_seen || (bus.M_WVALID && bus.M_WREADY))) begin
                bus.M_BVALID <= 1'b1;
                bus.M_BRESP  <= bresp_cfg;
                aw_seen      <= 1'b0;
                w_seen       <= 1'b0;
            end else begin
                if (bus.M_AWVALID && bus.M_AWREADY) aw_seen <= 1'b1;
                if (bus.M_WVALID && bus.M_WREADY)   w_seen  <= 1'b1;
            end
            if (bus.M_RVALID && bus.M_RREADY) bus.M_RVALID <= 1'b0;
            if (bus.M_ARVALID && bus.M_ARREADY) begin
                bus.M_RVALID <= 1'b1;
                bus.M_RDATA  <= bus.M_ARADDR;
                bus.M_RRESP  <= (bus.M_ARADDR == err_addr) ? 2'b10 : 2'b00;
                if (ar_cnt < 64) ar_log[ar_cnt] <= bus.M_ARADDR;
                ar_cnt <= ar_cnt + 1;
            end
        end
    end

    // Completion pulse counters
    always @(posedge clk) begin
        if (u_wdone) wdone_cnt <= wdone_cnt + 1;
        if (u_rdone) rdone_cnt <= rdone_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdone(input int max_cycles, output int n);
        n = 0;
        while (n < max_cycles) begin
            tick();
            n++;
            if (u_rdone) break;
        end
    endtask

    initial begin
        int n;
        int start;
        int wd0;
        int rd0;
        int low_run;
        int max_low;
        logic ar_seen_flag;

        // Reset state
        tick();
        tick();
        check("rst_busy", 64'(u_busy), 64'd0);
        check("rst_wdone", 64'(u_wdone), 64'd0);
        check("rst_rdone", 64'(u_rdone), 64'd0);
        check("rst_err", 64'(u_err), 64'd0);
        check("rst_rdata", 64'(u_rdata), 64'd0);
        check("rst_valids", 64'({bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID}), 64'd0);
        check("rst_readys", 64'({bus.M_BREADY, bus.M_RREADY}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Zero-wait write
        wd0 = wdone_cnt;
        u_wvalid = 1'b1; u_awaddr = 32'h0; u_wdata = 32'h0000_1234; u_strb = 4'hF;
        tick();
        u_wvalid = 1'b0;
        check("zw_awvalid", 64'(bus.M_AWVALID), 64'd1);
        check("zw_wvalid", 64'(bus.M_WVALID), 64'd1);
        check("zw_wdata", 64'(bus.M_WDATA), 64'h1234);
        check("zw_wstrb", 64'(bus.M_WSTRB), 64'hF);
        check("zw_busy", 64'(u_busy), 64'd1);
        tick();
        check("zw_bready", 64'(bus.M_BREADY), 64'd1);
        check("zw_valids_down", 64'({bus.M_AWVALID, bus.M_WVALID}), 64'd0);
        check("zw_wdone_early", 64'(u_wdone), 64'd0);
        tick();
        check("zw_wdone", 64'(u_wdone), 64'd1);
        check("zw_err", 64'(u_err), 64'd0);
        check("zw_busy_idle", 64'(u_busy), 64'd0);
        tick();
        check("zw_wdone_pulse", 64'(u_wdone), 64'd0);
        check("zw_wdone_cnt", 64'(wdone_cnt - wd0), 64'd1);

        // Skewed handshakes, error response
        wd0 = wdone_cnt;
        w_ready = 1'b0; bresp_cfg = 2'b10;
        u_wvalid = 1'b1; u_awaddr = 32'h100; u_wdata = 32'hCAFE_F00D; u_strb = 4'h3;
        tick();
        u_wvalid = 1'b0;
        check("sk_both_valid", 64'({bus.M_AWVALID, bus.M_WVALID}), 64'b11);
        check("sk_awaddr", 64'(bus.M_AWADDR), 64'h100);
        tick();
        check("sk_awvalid_drop", 64'(bus.M_AWVALID), 64'd0);
        check("sk_wvalid_held", 64'(bus.M_WVALID), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sk_wvalid_wait", 64'(bus.M_WVALID), 64'd1);
            check("sk_wdata_stable", 64'(bus.M_WDATA), 64'hCAFE_F00D);
            check("sk_no_wdone", 64'(u_wdone), 64'd0);
        end
        w_ready = 1'b1;
        tick();
        check("sk_wvalid_drop", 64'(bus.M_WVALID), 64'd0);
        check("sk_bready", 64'(bus.M_BREADY), 64'd1);
        tick();
        check("sk_wdone", 64'(u_wdone), 64'd1);
        check("sk_err", 64'(u_err), 64'd1);
        tick();
        check("sk_wdone_cnt", 64'(wdone_cnt - wd0), 64'd1);
        bresp_cfg = 2'b00;

        // 16-beat read, slave returns address as data
        rd0 = rdone_cnt;
        start = ar_cnt;
        u_rvalid = 1'b1; u_araddr = 32'h10; u_blen = 4'hF;
        tick();
        u_rvalid = 1'b0;
        check("rd16_arvalid", 64'(bus.M_ARVALID), 64'd1);
        check("rd16_araddr0", 64'(bus.M_ARADDR), 64'h10);
        wait_rdone(40, n);
        check("rd16_latency", 64'(n), 64'd32);
        check("rd16_rdata", 64'(u_rdata), 64'h4C);
        check("rd16_err", 64'(u_err), 64'd0);
        tick();
        check("rd16_rdone_cnt", 64'(rdone_cnt - rd0), 64'd1);
        check("rd16_beats", 64'(ar_cnt - start), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check("rd16_addr_seq", 64'(ar_log[start + i]), 64'(32'h10 + 32'(i) * 32'd4));
        end
        check("rd16_rdata_hold", 64'(u_rdata), 64'h4C);

        // Address wrap with error on beat 0
        err_addr = 32'hFFFF_FFFC;
        start = ar_cnt;
        u_rvalid = 1'b1; u_araddr = 32'hFFFF_FFFC; u_blen = 4'h1;
        tick();
        u_rvalid = 1'b0;
        wait_rdone(10, n);
        check("wrap_latency", 64'(n), 64'd4);
        check("wrap_rdone", 64'(u_rdone), 64'd1);
        check("wrap_err", 64'(u_err), 64'd1);
        check("wrap_rdata", 64'(u_rdata), 64'h0);
        check("wrap_addr0", 64'(ar_log[start]), 64'hFFFF_FFFC);
        check("wrap_addr1", 64'(ar_log[start + 1]), 64'h0);
        err_addr = 32'h0000_0BAD;
        tick();

        // Both requests held: writes repeat, read only after U_WVALID drops
        wd0 = wdone_cnt;
        rd0 = rdone_cnt;
        u_wvalid = 1'b1; u_awaddr = 32'h20; u_wdata = 32'h5555_AAAA; u_strb = 4'hF;
        u_rvalid = 1'b1; u_araddr = 32'h200; u_blen = 4'h0;
        ar_seen_flag = 1'b0;
        low_run = 0;
        max_low = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.M_ARVALID) ar_seen_flag = 1'b1;
            if (!u_busy) begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end else begin
                low_run = 0;
            end
        end
        check("lvl_last_is_idle_done", 64'({u_busy, u_wdone}), 64'b01);
        u_wvalid = 1'b0;
        tick();
        check("lvl_no_read_during_writes", 64'(ar_seen_flag), 64'd0);
        check("lvl_busy_low_run", 64'(max_low), 64'd1);
        check("lvl_wdone_cnt", 64'(wdone_cnt - wd0), 64'd4);
        check("lvl_read_follows", 64'(bus.M_ARVALID), 64'd1);
        check("lvl_read_addr", 64'(bus.M_ARADDR), 64'h200);
        u_rvalid = 1'b0;
        wait_rdone(10, n);
        check("lvl_read_rdata", 64'(u_rdata), 64'h200);
        tick();
        check("lvl_rdone_cnt", 64'(rdone_cnt - rd0), 64'd1);

        // Reset during beat 2 of a 4-beat read
        rd0 = rdone_cnt;
        u_rvalid = 1'b1; u_araddr = 32'h300; u_blen = 4'h3;
        tick();
        u_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mr_in_rd_r", 64'(bus.M_RREADY), 64'd1);
        check("mr_rdata_beat1", 64'(u_rdata), 64'h304);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_valids", 64'({bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID}), 64'd0);
        check("mr_async_readys", 64'({bus.M_BREADY, bus.M_RREADY}), 64'd0);
        check("mr_async_u", 64'({u_busy, u_wdone, u_rdone, u_err}), 64'd0);
        check("mr_async_rdata", 64'(u_rdata), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_idle_after", 64'(u_busy), 64'd0);
        u_rvalid = 1'b1; u_araddr = 32'h400; u_blen = 4'h0;
        tick();
        u_rvalid = 1'b0;
        check("mr_new_araddr", 64'(bus.M_ARADDR), 64'h400);
        wait_rdone(10, n);
        check("mr_new_latency", 64'(n), 64'd2);
        check("mr_new_rdata", 64'(u_rdata), 64'h400);
        check("mr_new_err", 64'(u_err), 64'd0);
        tick();
        check("mr_rdone_cnt", 64'(rdone_cnt - rd0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
